// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, diff_cat;
  logic [WIDTH-2:0] diff_sr;
  logic [CW-1:0] cnt;
  logic c, a_msb, b_msb, x, y, d, c_nx, last;
  assign x = a_sr[0];
  assign y = b_sr[0];
  assign d = x ^ y ^ c;
  assign c_nx = (~x & y) | (~(x ^ y) & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign diff_cat = {d, diff_sr};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && in_valid) ? SHIFT :
               (state == SHIFT && last)    ? DONE  :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sr  <= a;
      b_sr  <= b;
      c     <= 1'b0;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_cat[WIDTH-1:1];
      c       <= c_nx;
      cnt     <= last ? cnt : cnt + 1'b1;
      if (last) begin
        diff   <= diff_cat;
        borrow <= c_nx;
        ovf    <= (a_msb != b_msb) && (d != a_msb);
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized + directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, borrow, ovf, busy;
  logic [W-1:0] a = '0, b = '0, diff;
  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           cyc;
  } exp_t;
  exp_t q[$];
  int acc_q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit prev_ov = 1'b0, rnd_rdy = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    exp_t e;
    int sd, ux, uy;
    ux = int'(x);
    uy = int'(y);
    sd = int'($signed(x)) - int'($signed(y));
    e.d = W'(ux - uy + (1 << W));
    e.br = ux < uy;
    e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, cyc));
      acc_q.push_back(cyc);
    end
    chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      else begin
        if (!prev_ov) chk("latency", 32'(cyc - q[0].cyc), 32'(W + 1));
        chk("diff", 32'(diff), 32'(q[0].d));
        chk("borrow", 32'(borrow), 32'(q[0].br));
        chk("ovf", 32'(ovf), 32'(q[0].ov));
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    int n = 0;
    @(posedge clk);
    #1;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    if (!keep) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd5, 8'd3, 1'b0);
    drain();
    send(8'd3, 8'd5, 1'b0);
    drain();
    send(8'h80, 8'h01, 1'b0);
    drain();
    send(8'h7F, 8'hFF, 1'b0);
    drain();
    // backpressure: result must hold while in_valid pulses with junk operands
    out_ready = 1'b0;
    send(8'h5A, 8'h33, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a = W'($urandom);
      b = W'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();
    // reset during the 4th SHIFT cycle discards the operation
    send(8'hC3, 8'h19, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    acc_q.delete();
    prev_ov = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd0, 8'd0, 1'b0);
    drain();
    // back-to-back with in_valid and out_ready held high
    acc_q.delete();
    send(8'h10, 8'h20, 1'b1);
    send(8'hFF, 8'h01, 1'b1);
    send(8'h01, 8'h80, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    if (acc_q.size() == 3) begin
      chk("b2b_period_1", 32'(acc_q[1] - acc_q[0]), 32'(W + 2));
      chk("b2b_period_2", 32'(acc_q[2] - acc_q[1]), 32'(W + 2));
    end else chk("b2b_accept_count", 32'(acc_q.size()), 32'd3);
    // random operands with random consumer stalls
    rnd_rdy = 1'b1;
    repeat (30) begin
      send(W'($urandom), W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
